psum_acc_ctrl: RTL and testbench
================================

Name: psum_acc_ctrl

Overview:
Sequences partial-sum accumulation between the output FIFO of the MAC array and the PMEM/output SRAM across all kernel positions (kij passes). For each pass it pops n_out column vectors from the OFIFO, reads the matching PMEM word, adds lane-wise, and writes the result back. ReLU is applied optionally on the final pass. It replaces the fixed-count SFU_COMPUTE/OUT_SRAM_FILL timing in the corelet FSM with a valid-driven handshake.

Parameters:
col, 8, number of psum lanes per vector
psum_bw, 16, bits per psum lane (two's complement)
n_out, 16, output vectors per kij pass
n_kij, 9, number of kij passes per sequence
addr_w, 9, PMEM address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a sequence when idle
base_addr  in  addr_w  first PMEM address; sampled on accepted start
relu_en  in  1  apply ReLU on final pass; sampled on accepted start
ofifo_valid  in  1  OFIFO head holds a complete vector
ofifo_out  in  psum_bw*col  OFIFO head vector; lane i = bits [psum_bw*(i+1)-1 : psum_bw*i]
ofifo_rd  out  1  pop OFIFO head at this clock edge
pmem_q  in  psum_bw*col  PMEM read data; valid 1 cycle after read
pmem_addr  out  addr_w  PMEM address
pmem_cen  out  1  PMEM chip enable, active low
pmem_wen  out  1  PMEM write enable, active low
pmem_d  out  psum_bw*col  PMEM write data
busy  out  1  high from accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse at sequence end

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high, no other reset.
- Reset values and values while reset is asserted, including mid-sequence: state=IDLE, row=0, pass=0, ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_addr=0, pmem_d=0, busy=0, done=0, acc_reg=0. A sequence in progress is abandoned. Any PMEM contents already written are left as they are.
- States: IDLE, READ, WRITE, DONE.
- IDLE: if start=1, latch base_addr and relu_en, clear row and pass, then go to READ.
- READ: wait while ofifo_valid=0, holding all outputs deasserted. When ofifo_valid=1:
  - ofifo_rd=1 and acc_reg<=ofifo_out, then go to WRITE.
  - If pass>0: pmem_cen=0, pmem_wen=1, pmem_addr=base_addr+row.
  - If pass=0: pmem_cen=1 (no read).
- WRITE: pmem_cen=0, pmem_wen=0, pmem_addr=base_addr+row, ofifo_rd=0.
  - Per lane: sum = acc_reg_lane + (pass>0 ? pmem_q_lane : 0). Addition is modular at psum_bw bits, with no saturation.
  - If pass=n_kij-1 and relu_en=1 and a lane sum is negative, that lane is written as 0.
  - pmem_d is combinational from this sum. pmem_d=0 in every other state.
- Transitions out of WRITE:
  - row<n_out-1: row++, go to READ.
  - row=n_out-1 and pass<n_kij-1: row=0, pass++, go to READ.
  - Otherwise: go to DONE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Throughput: 2 cycles per vector. With ofifo_valid held at 1, done rises exactly 2*n_out*n_kij+1 cycles after the edge that accepts start (289 with the default parameters).
- start while busy=1 is ignored, with no queuing.
- Address wrap: base_addr+row is truncated to addr_w bits and wraps modulo 2^addr_w.
- ofifo_rd is never asserted when ofifo_valid=0.
- PMEM never sees a read and a write in the same cycle.

Decomposition:
- corelet_pkg holds:
  - the acc_state_t enum (IDLE, READ, WRITE, DONE);
  - default constants PSUM_BW=16, COL=8, N_OUT=16, N_KIJ=9.
- Sub-module psum_lane_add (params col, psum_bw): lane-wise modular add plus optional ReLU. Inputs: a, b, relu. Output: sum. Purely combinational, instantiated once.

Test Plan:
- Single sequence, ofifo always valid, every lane of every vector = 1, base_addr=0, relu_en=0 -> PMEM[0..15] every lane = 9; done high at cycle 289; exactly 144 ofifo_rd pulses.
- Lanes = -2 on every vector, relu_en=1 -> PMEM[0..15] all lanes 0. Same stimulus with relu_en=0 -> all lanes 0xFFEE (-18).
- ofifo_valid toggles 1-of-every-3 cycles -> ofifo_rd never asserted while valid=0; final PMEM contents identical to the first test; done delayed accordingly.
- base_addr=505 (9-bit) -> writes go to 505..511, then 0..8; no other addresses touched.
- Lanes = 0x7FFF on every pass, relu_en=0 -> result is modular: 9*0x7FFF mod 2^16 = 0x7FF7.
- Reset asserted for 1 cycle at cycle 100 -> next cycle all outputs at reset values and busy=0. A new start then completes normally, with second start during busy ignored (single done pulse).

Source files
------------

// File: rtl/psum_acc_ctrl_pkg.sv
// Shared types and default geometry for the corelet partial-sum path.
package corelet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int N_OUT   = 16;
  localparam int N_KIJ   = 9;
  localparam int ADDR_W  = 9;

endpackage

// File: rtl/psum_acc_ctrl_if.sv
// Control, OFIFO and PMEM signals of the partial-sum accumulation controller.
interface psum_acc_ctrl_if
  import corelet_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_w  = ADDR_W
);

  logic                     start;
  logic [addr_w-1:0]        base_addr;
  logic                     relu_en;
  logic                     busy;
  logic                     done;

  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;

  logic [col*psum_bw-1:0]   pmem_q;
  logic [addr_w-1:0]        pmem_addr;
  logic                     pmem_cen;
  logic                     pmem_wen;
  logic [col*psum_bw-1:0]   pmem_d;

  modport master (
    input  start, base_addr, relu_en, ofifo_valid, ofifo_out, pmem_q,
    output busy, done, ofifo_rd, pmem_addr, pmem_cen, pmem_wen, pmem_d
  );

  modport slave (
    output start, base_addr, relu_en, ofifo_valid, ofifo_out, pmem_q,
    input  busy, done, ofifo_rd, pmem_addr, pmem_cen, pmem_wen, pmem_d
  );

endinterface

// File: rtl/psum_acc_ctrl_lane_add.sv
// Lane-wise modular adder with optional per-lane ReLU clamp to zero.
module psum_lane_add #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a,
  input  logic [col*psum_bw-1:0] b,
  input  logic                   relu,
  output logic [col*psum_bw-1:0] sum
);

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] w_raw;

    // Carry out of the lane is dropped, so the sum wraps rather than saturates.
    assign w_raw = a[i*psum_bw +: psum_bw] + b[i*psum_bw +: psum_bw];
    assign sum[i*psum_bw +: psum_bw] = (relu && w_raw[psum_bw-1]) ? '0 : w_raw;
  end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Valid-driven sequencer that folds OFIFO vectors into PMEM across all kij passes,
// two cycles per vector: pop + PMEM read, then add + PMEM write.
module psum_acc_ctrl
  import corelet_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int n_out   = N_OUT,
  parameter int n_kij   = N_KIJ,
  parameter int addr_w  = ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  psum_acc_ctrl_if.master  bus
);

  localparam int ROW_W  = (n_out > 1) ? $clog2(n_out) : 1;
  localparam int PASS_W = (n_kij > 1) ? $clog2(n_kij) : 1;
  localparam int VEC_W  = col * psum_bw;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(n_out - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(n_kij - 1);

  acc_state_t         r_state;
  logic [ROW_W-1:0]   r_row;
  logic [PASS_W-1:0]  r_pass;
  logic [addr_w-1:0]  r_base;
  logic               r_relu_en;
  logic [VEC_W-1:0]   r_acc;

  logic [addr_w-1:0]  w_addr;
  logic               w_pass_nz;
  logic               w_last_pass;
  logic [VEC_W-1:0]   w_addend;
  logic [VEC_W-1:0]   w_sum;

  assign w_addr      = r_base + addr_w'(r_row);
  assign w_pass_nz   = (r_pass != '0);
  assign w_last_pass = (r_pass == LAST_PASS);
  // First pass has nothing in PMEM yet, so the OFIFO vector is written as-is.
  assign w_addend    = w_pass_nz ? bus.pmem_q : '0;

  psum_lane_add #(
    .col     (col),
    .psum_bw (psum_bw)
  ) u_lane_add (
    .a    (r_acc),
    .b    (w_addend),
    .relu (r_relu_en && w_last_pass),
    .sum  (w_sum)
  );

  // NOTE: state registers use non-blocking assignments so every register in this
  // block sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_pass    <= '0;
      r_base    <= '0;
      r_relu_en <= 1'b0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_base    <= bus.base_addr;
            r_relu_en <= bus.relu_en;
            r_row     <= '0;
            r_pass    <= '0;
            r_state   <= READ;
          end
        end
        READ: begin
          if (bus.ofifo_valid) begin
            r_acc   <= bus.ofifo_out;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (r_row != LAST_ROW) begin
            r_row   <= r_row + 1'b1;
            r_state <= READ;
          end else if (!w_last_pass) begin
            r_row   <= '0;
            r_pass  <= r_pass + 1'b1;
            r_state <= READ;
          end else begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets its idle value first, so no path through the case
  // leaves one unassigned and no latch is inferred. Outputs are decoded here
  // rather than registered because the OFIFO pop and PMEM read must happen in
  // the same cycle that ofifo_valid is seen.
  always_comb begin
    bus.ofifo_rd  = 1'b0;
    bus.pmem_cen  = 1'b1;
    bus.pmem_wen  = 1'b1;
    bus.pmem_addr = '0;
    bus.pmem_d    = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    if (!reset) begin
      bus.busy = (r_state != IDLE);
      case (r_state)
        READ: begin
          if (bus.ofifo_valid) begin
            bus.ofifo_rd = 1'b1;
            if (w_pass_nz) begin
              bus.pmem_cen  = 1'b0;
              bus.pmem_addr = w_addr;
            end
          end
        end
        WRITE: begin
          bus.pmem_cen  = 1'b0;
          bus.pmem_wen  = 1'b0;
          bus.pmem_addr = w_addr;
          bus.pmem_d    = w_sum;
        end
        DONE:    bus.done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Scoreboard bench for psum_acc_ctrl: a PMEM model, an OFIFO driver and a write monitor.
`timescale 1ns/1ps
module tb_psum_acc_ctrl;
  import corelet_pkg::*;

  localparam int VW    = COL * PSUM_BW;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NVEC  = N_OUT * N_KIJ;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VW-1:0]     data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_acc_ctrl_if bus ();

  psum_acc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t          exp_q[$];
  wr_t          mon_e;
  logic [VW-1:0] mem [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_total = 0;
  int done_total = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PMEM: one-cycle read latency, write on the edge.
  always @(posedge clk) begin
    if (!bus.pmem_cen && bus.pmem_wen) bus.pmem_q <= mem[bus.pmem_addr];
    if (!bus.pmem_cen && !bus.pmem_wen) mem[bus.pmem_addr] <= bus.pmem_d;
  end

  // Monitor: pops the expected write for every PMEM write the DUT presents.
  always @(negedge clk) begin
    if (bus.ofifo_rd) begin
      rd_total++;
      check("ofifo_rd_while_valid", VW'(bus.ofifo_valid), VW'(1));
    end
    if (bus.done) done_total++;
    if (!bus.pmem_cen && !bus.pmem_wen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %h, nothing expected", bus.pmem_addr, bus.pmem_d);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", VW'(bus.pmem_addr), VW'(mon_e.addr));
        check("wr_data", bus.pmem_d, mon_e.data);
      end
    end
  end

  task automatic push_expected(input int base, input logic [PSUM_BW-1:0] v, input bit relu);
    logic [PSUM_BW-1:0] s;
    wr_t e;
    for (int p = 0; p < N_KIJ; p++) begin
      s = PSUM_BW'((p + 1) * v);
      if (relu && p == N_KIJ - 1 && s[PSUM_BW-1]) s = '0;
      for (int r = 0; r < N_OUT; r++) begin
        e.addr = ADDR_W'(base + r);
        e.data = {COL{s}};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ofifo_rd"},  VW'(bus.ofifo_rd),  VW'(0));
    check({tag, "_pmem_cen"},  VW'(bus.pmem_cen),  VW'(1));
    check({tag, "_pmem_wen"},  VW'(bus.pmem_wen),  VW'(1));
    check({tag, "_pmem_addr"}, VW'(bus.pmem_addr), VW'(0));
    check({tag, "_pmem_d"},    bus.pmem_d,         VW'(0));
    check({tag, "_busy"},      VW'(bus.busy),      VW'(0));
    check({tag, "_done"},      VW'(bus.done),      VW'(0));
  endtask

  // Pulses start; returns #1 after the accepting edge with base/relu scrambled.
  task automatic start_seq(input int base, input logic [PSUM_BW-1:0] v, input bit relu);
    @(posedge clk); #1;
    bus.base_addr   = ADDR_W'(base);
    bus.relu_en     = relu;
    bus.ofifo_out   = {COL{v}};
    bus.ofifo_valid = 1'b0;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = ADDR_W'(base + 77);
    bus.relu_en   = ~relu;
  endtask

  task automatic run_seq(input string name, input int base, input logic [PSUM_BW-1:0] v,
                         input bit relu, input bit toggle, input bit restart_mid,
                         input int exp_done, input logic [PSUM_BW-1:0] exp_final);
    int rd0, dn0, k;
    bit seen;
    push_expected(base, v, relu);
    rd0 = rd_total;
    dn0 = done_total;
    start_seq(base, v, relu);
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 1500) begin
      bus.ofifo_valid = toggle ? (k % 3 == 1) : 1'b1;
      bus.start = restart_mid && (k == 50);
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, k);
    end else begin
      check({name, "_done_cycle"}, VW'(k), VW'(exp_done));
    end
    bus.ofifo_valid = 1'b0;
    bus.start       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_busy_after"}, VW'(bus.busy), VW'(0));
    check({name, "_rd_pulses"}, VW'(rd_total - rd0), VW'(NVEC));
    check({name, "_done_pulses"}, VW'(done_total - dn0), VW'(1));
    check({name, "_writes_left"}, VW'(exp_q.size()), VW'(0));
    exp_q.delete();
    for (int r = 0; r < N_OUT; r++)
      check({name, "_final"}, mem[(base + r) % DEPTH], {COL{exp_final}});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.relu_en     = 1'b0;
    bus.ofifo_valid = 1'b0;
    bus.ofifo_out   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_seq("ones",       0,   16'h0001, 1'b0, 1'b0, 1'b0, 289, 16'h0009);
    run_seq("neg_relu",   0,   16'hFFFE, 1'b1, 1'b0, 1'b0, 289, 16'h0000);
    run_seq("neg_norelu", 0,   16'hFFFE, 1'b0, 1'b0, 1'b0, 289, 16'hFFEE);
    run_seq("toggle",     0,   16'h0001, 1'b0, 1'b1, 1'b0, 432, 16'h0009);
    run_seq("wrap",       505, 16'h0001, 1'b0, 1'b0, 1'b0, 289, 16'h0009);
    run_seq("modular",    0,   16'h7FFF, 1'b0, 1'b0, 1'b0, 289, 16'h7FF7);

    // Abort a sequence with a one-cycle reset in cycle 100.
    push_expected(0, 16'h0003, 1'b0);
    start_seq(0, 16'h0003, 1'b0);
    for (int k = 1; k < 100; k++) begin
      bus.ofifo_valid = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.ofifo_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_abort");
    exp_q.delete();

    run_seq("restart", 0, 16'h0001, 1'b0, 1'b0, 1'b1, 289, 16'h0009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
